muldiv_sequencer: RTL and testbench

//  Iterative signed multiply/divide engine plus its sequencer, shared by MULT and DIV.

---
 rtl/muldiv_pkg.sv | 14 +
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_sequencer.sv | 151 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer and its control unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add for MULT, restoring trial
// subtract for DIV. For DIV the new quotient bit lands in q_o[0].
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op_i,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] addend;
    logic [WIDTH:0] shl;
    logic [WIDTH:0] trial;

    always_comb begin
        sum    = acc_i + {1'b0, m_i};
        addend = q_i[0] ? sum : acc_i;
        shl    = {acc_i[WIDTH-1:0], q_i[WIDTH-1]};
        trial  = shl - {1'b0, m_i};
        acc_o  = '0;
        q_o    = '0;
        if (op_i == OP_DIV) begin
            // shl and m both stay below 2**WIDTH, so trial[WIDTH] is the borrow.
            if (!trial[WIDTH]) begin
                acc_o = trial;
            end else begin
                acc_o = shl;
            end
            q_o = {q_i[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            acc_o = {1'b0, addend[WIDTH:1]};
            q_o   = {addend[0], q_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT/DIV engine: latches magnitudes, runs WIDTH radix-2 steps,
// applies signs and presents the MIPS Hi/Lo result with a done/load handshake.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             load_hi,
    output logic             load_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output logic [1:0]       dbg_state_o
);

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic               op_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH:0]     acc_d;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   q_d;
    logic [WIDTH-1:0]   m_q;
    logic               busy_q;
    logic               done_q;
    logic               load_q;
    logic               dz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op_i  (op_q),
        .acc_i (acc_q),
        .q_i   (q_q),
        .m_i   (m_q),
        .acc_o (acc_d),
        .q_o   (q_d)
    );

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;
    end

    always_comb begin
        prod     = {acc_q[WIDTH-1:0], q_q};
        prod_fix = neg_res_q ? -prod : prod;
        hi_d     = '0;
        lo_d     = '0;
        if (op_q == OP_MULT) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end else begin
            lo_d = neg_res_q ? -q_q : q_q;
            hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            op_q      <= OP_MULT;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            q_q       <= '0;
            m_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            load_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        q_q       <= a_mag;
                        m_q       <= b_mag;
                        acc_q     <= '0;
                        count_q   <= '0;
                        neg_res_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem_q <= a[WIDTH-1];
                        busy_q    <= 1'b1;
                        if (op == OP_DIV && b == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            dz_q    <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    load_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    load_q  <= 1'b0;
                    dz_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign load_hi     = load_q;
    assign load_lo     = load_q;
    assign div_zero    = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed corner cases plus random MULT/DIV against a
// 64-bit signed arithmetic reference.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         load_hi;
    logic         load_lo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;
    logic [1:0]   dbg_state;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_fail   = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .load_hi     (load_hi),
        .load_lo     (load_lo),
        .hi          (hi),
        .lo          (lo),
        .div_zero    (div_zero),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: full-precision signed arithmetic; Hi/Lo hold on divide-by-zero.
    task automatic model(input logic op_v, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] eh, output logic [W-1:0] el,
                         output logic edz, output int elat);
        longint sa;
        longint sb;
        longint r;
        sa   = longint'($signed(av));
        sb   = longint'($signed(bv));
        edz  = 1'b0;
        elat = 34;
        eh   = model_hi;
        el   = model_lo;
        if (op_v == OP_MULT) begin
            r  = sa * sb;
            eh = r[63:32];
            el = r[31:0];
        end else if (bv == '0) begin
            edz  = 1'b1;
            elat = 1;
        end else begin
            r  = sa / sb;
            el = r[31:0];
            r  = sa % sb;
            eh = r[31:0];
        end
        model_hi = eh;
        model_lo = el;
    endtask

    task automatic run_op(input string tag, input logic op_v, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input bit poke);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic [W-1:0] ph;
        logic [W-1:0] pl;
        logic         edz;
        int           elat;
        int           n;
        bit           unstable;
        ph = model_hi;
        pl = model_lo;
        model(op_v, av, bv, eh, el, edz, elat);
        start = 1'b1;
        op    = op_v;
        a     = av;
        b     = bv;
        tick();
        start    = 1'b0;
        n        = 1;
        unstable = 1'b0;
        check({tag, "_busy_c1"}, busy, 1);
        while (!done && n < 60) begin
            if (hi !== ph || lo !== pl) unstable = 1'b1;
            if (poke && n == 10) begin
                start = 1'b1;
                op    = ~op_v;
                a     = $urandom;
                b     = $urandom;
            end
            tick();
            start = 1'b0;
            n++;
        end
        check({tag, "_latency"}, n, elat);
        check({tag, "_done"}, done, 1);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        check({tag, "_load_hi"}, load_hi, !edz);
        check({tag, "_load_lo"}, load_lo, !edz);
        check({tag, "_div_zero"}, div_zero, edz);
        check({tag, "_busy_done"}, busy, 1);
        check({tag, "_hilo_stable"}, unstable, 0);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_load_pulse"}, load_hi, 0);
        check({tag, "_dz_pulse"}, div_zero, 0);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_state_end"}, dbg_state, 2'(S_IDLE));
        check({tag, "_hi_hold"}, hi, eh);
        check({tag, "_lo_hold"}, lo, el);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'h8000_0000;
            1:       v = '0;
            2:       v = '1;
            3:       v = W'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        bit seen_done;
        rst_n = 1'b0;
        start = 1'b0;
        op    = OP_MULT;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_load_hi", load_hi, 0);
        check("rst_load_lo", load_lo, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_state", dbg_state, 2'(S_IDLE));
        rst_n = 1'b1;
        tick();

        run_op("mul_7_m3", OP_MULT, 32'd7, -32'sd3, 1'b0);
        check("mul_7_m3_hi_lit", hi, 32'hFFFF_FFFF);
        check("mul_7_m3_lo_lit", lo, 32'hFFFF_FFEB);

        run_op("mul_min_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("mul_min_min_hi_lit", hi, 32'h4000_0000);
        check("mul_min_min_lo_lit", lo, 32'h0000_0000);

        run_op("div_m7_2", OP_DIV, -32'sd7, 32'd2, 1'b0);
        check("div_m7_2_lo_lit", lo, 32'hFFFF_FFFD);
        check("div_m7_2_hi_lit", hi, 32'hFFFF_FFFF);

        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_min_m1_lo_lit", lo, 32'h8000_0000);
        check("div_min_m1_hi_lit", hi, 32'h0);

        run_op("preload", OP_DIV, 32'h451, 32'h20, 1'b0);
        check("preload_hi_lit", hi, 32'h11);
        check("preload_lo_lit", lo, 32'h22);
        run_op("div_by_zero", OP_DIV, 32'd5, 32'd0, 1'b0);
        check("div_by_zero_hi_lit", hi, 32'h11);
        check("div_by_zero_lo_lit", lo, 32'h22);

        run_op("mul_poke", OP_MULT, 32'd1000, -32'sd77, 1'b1);
        run_op("div_poke", OP_DIV, -32'sd123457, 32'd321, 1'b1);

        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd123;
        b     = 32'd456;
        tick();
        start = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_state", dbg_state, 2'(S_IDLE));
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        seen_done = 1'b0;
        repeat (3) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check("midrst_no_done", seen_done, 0);
        rst_n    = 1'b1;
        model_hi = '0;
        model_lo = '0;
        tick();
        run_op("after_rst_6x7", OP_MULT, 32'd6, 32'd7, 1'b0);
        check("after_rst_lo_lit", lo, 32'd42);

        for (int i = 0; i < 40; i++) begin
            logic         rop;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rop = 1'($urandom_range(0, 1));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op($sformatf("rnd%0d", i), rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
